// File: rtl/laa_alu_mc.sv
// laa_alu_mc: registered, valid/ready handshaked ALU with an optional iterative RV32M multiplier
//
// Ports:
//   alu_i_clk        clock, all state changes on the rising edge
//   alu_i_rst        synchronous active-high reset
//   alu_i_flush      synchronous abort of any in-flight op and of the held result
//   alu_i_valid      request valid; accepted when alu_i_valid & alu_o_ready
//   alu_o_ready      request can be accepted this cycle
//   alu_i_op         ALU op code; for multiplies bits [1:0] select MUL/MULH/MULHSU/MULHU
//   alu_i_mul        request is a multiply (ignored when MUL_EN=0)
//   alu_i_a          operand A (rs1)
//   alu_i_b          operand B (rs2/imm)
//   alu_o_valid      result valid, held until alu_i_out_ready
//   alu_i_out_ready  consumer takes the result
//   alu_o            registered result
//   alu_o_zero       alu_o == 0, registered with alu_o
module laa_alu_mc #(
    parameter int XLEN   = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic            alu_i_clk,
    input  logic            alu_i_rst,
    input  logic            alu_i_flush,
    input  logic            alu_i_valid,
    output logic            alu_o_ready,
    input  logic [3:0]      alu_i_op,
    input  logic            alu_i_mul,
    input  logic [XLEN-1:0] alu_i_a,
    input  logic [XLEN-1:0] alu_i_b,
    output logic            alu_o_valid,
    input  logic            alu_i_out_ready,
    output logic [XLEN-1:0] alu_o,
    output logic            alu_o_zero
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW-1:0] LAST = SHW'(XLEN - 1);
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_LT  = 4'd2;
    localparam logic [3:0] ALU_SLT = 4'd3;
    localparam logic [3:0] ALU_AND = 4'd4;
    localparam logic [3:0] ALU_OR  = 4'd5;
    localparam logic [3:0] ALU_XOR = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
    localparam logic [3:0] ALU_SRA = 4'd9;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t            r_state;
    logic [SHW-1:0]    r_cnt;
    logic [2*XLEN-1:0] r_acc;
    logic [2*XLEN-1:0] r_mcand;
    logic [XLEN:0]     r_mplier;
    logic              r_neg;
    logic              r_hi;
    logic              r_valid;
    logic [XLEN-1:0]   r_out;
    logic              r_zero;

    logic              w_ready;
    logic              w_acc;
    logic              w_is_mul;
    logic [SHW-1:0]    w_sh;
    logic [XLEN-1:0]   w_res;
    logic              w_sa;
    logic              w_sb;
    logic [XLEN:0]     w_a_ext;
    logic [XLEN:0]     w_b_ext;
    logic [XLEN:0]     w_a_mag;
    logic [XLEN:0]     w_b_mag;
    logic [2*XLEN-1:0] w_sum;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_mres;

    assign w_ready  = (r_state == S_IDLE) & ~alu_i_flush & (~r_valid | alu_i_out_ready);
    assign w_acc    = alu_i_valid & w_ready;
    assign w_is_mul = MUL_EN & alu_i_mul;
    assign w_sh     = alu_i_b[SHW-1:0];

    always_comb begin
        w_res = alu_i_a;
        case (alu_i_op)
            ALU_ADD: w_res = alu_i_a + alu_i_b;
            ALU_SUB: w_res = alu_i_a - alu_i_b;
            ALU_LT:  w_res = {{(XLEN-1){1'b0}}, alu_i_a < alu_i_b};
            ALU_SLT: w_res = {{(XLEN-1){1'b0}}, $signed(alu_i_a) < $signed(alu_i_b)};
            ALU_AND: w_res = alu_i_a & alu_i_b;
            ALU_OR:  w_res = alu_i_a | alu_i_b;
            ALU_XOR: w_res = alu_i_a ^ alu_i_b;
            ALU_SLL: w_res = alu_i_a << w_sh;
            ALU_SRL: w_res = alu_i_a >> w_sh;
            ALU_SRA: w_res = $signed(alu_i_a) >>> w_sh;
            default: w_res = alu_i_a;
        endcase
    end

    // op[1:0]: 00 MUL, 01 MULH (s x s), 10 MULHSU (s x u), 11 MULHU (u x u).
    // One extra bit keeps the magnitude of the most-negative value exact.
    assign w_sa    = alu_i_op[1:0] != 2'b11;
    assign w_sb    = ~alu_i_op[1];
    assign w_a_ext = {w_sa & alu_i_a[XLEN-1], alu_i_a};
    assign w_b_ext = {w_sb & alu_i_b[XLEN-1], alu_i_b};
    assign w_a_mag = w_a_ext[XLEN] ? -w_a_ext : w_a_ext;
    assign w_b_mag = w_b_ext[XLEN] ? -w_b_ext : w_b_ext;

    // Final step folded in combinationally so the result lands on the last step edge.
    assign w_sum  = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_prod = r_neg ? -w_sum : w_sum;
    assign w_mres = r_hi ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];

    always_ff @(posedge alu_i_clk) begin
        if (alu_i_rst) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_out   <= '0;
            r_zero  <= 1'b1;
            r_cnt   <= '0;
        end else if (alu_i_flush) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_zero  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            if (alu_i_out_ready)
                r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_acc && w_is_mul) begin
                        r_state  <= S_MUL;
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_mcand  <= {{(XLEN-1){1'b0}}, w_a_mag};
                        r_mplier <= w_b_mag;
                        r_neg    <= w_a_ext[XLEN] ^ w_b_ext[XLEN];
                        r_hi     <= alu_i_op[1:0] != 2'b00;
                    end else if (w_acc) begin
                        r_out   <= w_res;
                        r_zero  <= w_res == '0;
                        r_valid <= 1'b1;
                    end
                end
                S_MUL: begin
                    r_acc    <= w_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_state <= S_IDLE;
                        r_out   <= w_mres;
                        r_zero  <= w_mres == '0;
                        r_valid <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign alu_o_ready = w_ready;
    assign alu_o_valid = r_valid;
    assign alu_o       = r_out;
    assign alu_o_zero  = r_zero;
endmodule

// File: tb/tb_laa_alu_mc.sv
// tb_laa_alu_mc: table-driven scoreboard bench for laa_alu_mc plus XLEN=16 and MUL_EN=0 variants
module tb_laa_alu_mc;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_LT  = 4'd2;
    localparam logic [3:0] OP_SLT = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_SLL = 4'd7;
    localparam logic [3:0] OP_SRL = 4'd8;
    localparam logic [3:0] OP_SRA = 4'd9;
    localparam logic [3:0] M_MUL    = 4'd0;
    localparam logic [3:0] M_MULH   = 4'd1;
    localparam logic [3:0] M_MULHSU = 4'd2;
    localparam logic [3:0] M_MULHU  = 4'd3;

    typedef struct {
        logic [3:0]  op;
        logic        mul;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          t0;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, valid, mul, out_ready;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        o_ready, o_valid, o_zero;
    logic [31:0] o_res;

    logic        h_valid, h_mul, h_ready, h_ovalid, h_zero;
    logic [3:0]  h_op;
    logic [15:0] h_a, h_b, h_res;

    logic        n_valid, n_mul, n_ready, n_ovalid, n_zero;
    logic [3:0]  n_op;
    logic [31:0] n_a, n_b, n_res;

    logic        x_rdy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[$];

    laa_alu_mc #(.XLEN(32), .MUL_EN(1'b1)) u_dut (
        .alu_i_clk(clk), .alu_i_rst(rst), .alu_i_flush(flush),
        .alu_i_valid(valid), .alu_o_ready(o_ready), .alu_i_op(op), .alu_i_mul(mul),
        .alu_i_a(a), .alu_i_b(b), .alu_o_valid(o_valid), .alu_i_out_ready(out_ready),
        .alu_o(o_res), .alu_o_zero(o_zero)
    );

    laa_alu_mc #(.XLEN(16), .MUL_EN(1'b1)) u_h16 (
        .alu_i_clk(clk), .alu_i_rst(rst), .alu_i_flush(flush),
        .alu_i_valid(h_valid), .alu_o_ready(h_ready), .alu_i_op(h_op), .alu_i_mul(h_mul),
        .alu_i_a(h_a), .alu_i_b(h_b), .alu_o_valid(h_ovalid), .alu_i_out_ready(x_rdy),
        .alu_o(h_res), .alu_o_zero(h_zero)
    );

    laa_alu_mc #(.XLEN(32), .MUL_EN(1'b0)) u_nomul (
        .alu_i_clk(clk), .alu_i_rst(rst), .alu_i_flush(flush),
        .alu_i_valid(n_valid), .alu_o_ready(n_ready), .alu_i_op(n_op), .alu_i_mul(n_mul),
        .alu_i_a(n_a), .alu_i_b(n_b), .alu_o_valid(n_ovalid), .alu_i_out_ready(x_rdy),
        .alu_o(n_res), .alu_o_zero(n_zero)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] o, input logic m, input logic [31:0] x,
                                input logic [31:0] y, input logic [31:0] r, input int l);
        vec_t v;
        v.op = o;
        v.mul = m;
        v.a = x;
        v.b = y;
        v.res = r;
        v.lat = l;
        return v;
    endfunction

    always @(negedge clk) begin
        if (!rst && o_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got 0x%08h, expected none", o_res);
            end else begin
                mon_e = sb.pop_front();
                check("result", o_res, mon_e.res);
                check("zero_flag", {31'b0, o_zero}, {31'b0, mon_e.res == 32'd0});
                if (mon_e.lat >= 0)
                    check("latency", 32'(cyc - mon_e.t0), 32'(mon_e.lat));
            end
        end
    end

    task automatic issue(input vec_t v, input bit push);
        exp_t e;
        bit got;
        op = v.op;
        mul = v.mul;
        a = v.a;
        b = v.b;
        valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            got = o_ready;
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got ready=0 for 100 cycles, expected ready=1");
        end else if (push) begin
            e.res = v.res;
            e.lat = v.lat;
            e.t0 = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(posedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        #1;
    endtask

    task automatic run16(input logic [3:0] o, input logic m, input logic [15:0] x,
                         input logic [15:0] y, input logic [15:0] r, input int lat);
        int t0;
        bit got;
        h_op = o;
        h_mul = m;
        h_a = x;
        h_b = y;
        h_valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            got = h_ready;
        end
        t0 = cyc;
        @(posedge clk);
        #1;
        h_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            got = h_ovalid;
        end
        check("x16_result", {16'b0, h_res}, {16'b0, r});
        check("x16_latency", 32'(cyc - t0), 32'(lat));
        @(posedge clk);
        #1;
    endtask

    task automatic run_nm(input logic [3:0] o, input logic m, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] r);
        int t0;
        bit got;
        n_op = o;
        n_mul = m;
        n_a = x;
        n_b = y;
        n_valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            got = n_ready;
        end
        t0 = cyc;
        @(posedge clk);
        #1;
        n_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            got = n_ovalid;
        end
        check("nomul_result", n_res, r);
        check("nomul_latency", 32'(cyc - t0), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst = 1'b1; flush = 1'b0; valid = 1'b0; mul = 1'b0; op = '0; a = '0; b = '0;
        out_ready = 1'b1; x_rdy = 1'b1;
        h_valid = 1'b0; h_mul = 1'b0; h_op = '0; h_a = '0; h_b = '0;
        n_valid = 1'b0; n_mul = 1'b0; n_op = '0; n_a = '0; n_b = '0;

        tbl.push_back(mk(OP_ADD, 1'b0, 32'd7, 32'd9, 32'd16, 1));
        tbl.push_back(mk(OP_SUB, 1'b0, 32'd3, 32'd5, 32'hFFFF_FFFE, 1));
        tbl.push_back(mk(OP_SRA, 1'b0, 32'h8000_0000, 32'h24, 32'hF800_0000, 1));
        tbl.push_back(mk(OP_SLT, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1));
        tbl.push_back(mk(OP_LT,  1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1));
        tbl.push_back(mk(OP_AND, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1));
        tbl.push_back(mk(OP_OR,  1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 1));
        tbl.push_back(mk(OP_XOR, 1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1));
        tbl.push_back(mk(OP_SLL, 1'b0, 32'd3, 32'h21, 32'd6, 1));
        tbl.push_back(mk(OP_SRL, 1'b0, 32'h8000_0000, 32'h1F, 32'd1, 1));
        tbl.push_back(mk(4'hC,   1'b0, 32'h1234_5678, 32'd1, 32'h1234_5678, 1));
        tbl.push_back(mk(OP_ADD, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1));
        tbl.push_back(mk(M_MULH,   1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33));
        tbl.push_back(mk(M_MULHU,  1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33));
        tbl.push_back(mk(M_MUL,    1'b1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 33));
        tbl.push_back(mk(M_MULHSU, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33));
        tbl.push_back(mk(M_MUL,    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33));
        tbl.push_back(mk(M_MULH,   1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000, 33));
        tbl.push_back(mk(M_MULHU,  1'b1, 32'd0, 32'h0001_2345, 32'd0, 33));

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", {31'b0, o_valid}, 32'd0);
        check("rst_zero", {31'b0, o_zero}, 32'd1);
        check("rst_ready", {31'b0, o_ready}, 32'd1);
        check("rst_out", o_res, 32'd0);
        @(posedge clk);
        #1;

        foreach (tbl[i]) issue(tbl[i], 1'b1);
        drain();

        out_ready = 1'b0;
        issue(mk(OP_ADD, 1'b0, 32'd1, 32'd1, 32'd2, -1), 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", {31'b0, o_valid}, 32'd1);
            check("bp_hold", o_res, 32'd2);
            check("bp_ready", {31'b0, o_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(mk(OP_XOR, 1'b0, 32'd5, 32'd3, 32'd6, 1), 1'b1);
        @(negedge clk);
        check("bp_valid_stays", {31'b0, o_valid}, 32'd1);
        drain();

        issue(mk(M_MUL, 1'b1, 32'd3, 32'd4, 32'd12, 33), 1'b0);
        repeat (9) @(posedge clk);
        #1;
        check("mul_busy_ready", {31'b0, o_ready}, 32'd0);
        flush = 1'b1;
        @(negedge clk);
        check("flush_ready", {31'b0, o_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("post_flush_ready", {31'b0, o_ready}, 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= o_valid;
        end
        check("flush_no_result", {31'b0, seen}, 32'd0);
        @(posedge clk);
        #1;
        issue(mk(OP_ADD, 1'b0, 32'd2, 32'd2, 32'd4, 1), 1'b1);
        drain();

        out_ready = 1'b0;
        issue(mk(OP_ADD, 1'b0, 32'd5, 32'd6, 32'd11, 1), 1'b0);
        @(negedge clk);
        check("held_out", o_res, 32'd11);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_valid", {31'b0, o_valid}, 32'd0);
        check("flush_zero", {31'b0, o_zero}, 32'd1);
        check("flush_keeps_out", o_res, 32'd11);
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        issue(mk(M_MULHU, 1'b1, 32'hFFFF_FFFF, 32'd7, 32'd6, 33), 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", {31'b0, o_valid}, 32'd0);
        check("rst_mid_out", o_res, 32'd0);
        check("rst_mid_ready", {31'b0, o_ready}, 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= o_valid;
        end
        check("rst_no_result", {31'b0, seen}, 32'd0);
        @(posedge clk);
        #1;

        run16(OP_ADD, 1'b0, 16'd7, 16'd9, 16'd16, 1);
        run16(OP_SUB, 1'b0, 16'd3, 16'd5, 16'hFFFE, 1);
        run16(OP_SRA, 1'b0, 16'h8000, 16'h24, 16'hF800, 1);
        run16(M_MULH, 1'b1, 16'h8000, 16'h8000, 16'h4000, 17);
        run16(M_MULHU, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFE, 17);
        run16(M_MUL, 1'b1, 16'hFFFD, 16'd5, 16'hFFF1, 17);

        run_nm(OP_ADD, 1'b0, 32'd7, 32'd9, 32'd16);
        run_nm(OP_SUB, 1'b0, 32'd3, 32'd5, 32'hFFFF_FFFE);
        run_nm(OP_SRA, 1'b0, 32'h8000_0000, 32'h24, 32'hF800_0000);
        run_nm(M_MULH, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'd0);
        run_nm(M_MULHU, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
        run_nm(M_MUL, 1'b1, 32'hFFFF_FFFD, 32'd5, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
